// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: state encoding, queue depth, PC step, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  localparam int          FETCH_Q_DEPTH = 2;
  localparam int          FETCH_CNT_W   = $clog2(FETCH_Q_DEPTH + 1);
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request bus: req/ready handshake, data returned in the accept cycle.
// Latency: combinational wires only.
// Backpressure: memory holds off a request by keeping imem_ready low; master keeps addr stable.
// Ports (master view): imem_req, imem_addr out; imem_ready, imem_rdata in.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of fetched {pc+4, instr}; entry 0 is always the head register.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full without a simultaneous pop; pop ignored when empty.
// Ports: clk_i, rst_i (sync, active-low), clear, push, push_dat, pop, head_dat, count, full, empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_DAT = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [FETCH_CNT_W-1:0] count,
  output logic                   full,
  output logic                   empty
);
  localparam logic [FETCH_CNT_W-1:0] DEPTH = FETCH_CNT_W'(FETCH_Q_DEPTH);
  localparam logic [FETCH_CNT_W-1:0] ONE   = FETCH_CNT_W'(1);

  logic [W-1:0]           ent0;
  logic [W-1:0]           ent1;
  logic [FETCH_CNT_W-1:0] cnt;

  assign head_dat = ent0;
  assign count    = cnt;
  assign full     = (cnt == DEPTH);
  assign empty    = (cnt == '0);

  // Shift-style storage keeps the head in a fixed register so downstream sees flop outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ent0 <= RST_DAT;
      ent1 <= RST_DAT;
      cnt  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!full) begin
            if (empty) ent0 <= push_dat;
            else       ent1 <= push_dat;
            cnt <= cnt + ONE;
          end
        end
        2'b01: begin
          if (!empty) begin
            ent0 <= ent1;
            cnt  <= cnt - ONE;
          end
        end
        2'b11: begin
          if (empty) begin
            ent0 <= push_dat;
            cnt  <= ONE;
          end else if (cnt == ONE) begin
            ent0 <= push_dat;
          end else begin
            ent0 <= ent1;
            ent1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests imem, queues {pc+4, instr} for IF/ID, handles redirects.
// Latency: instruction reaches valid_o one cycle after its memory handshake.
// Backpressure: stall_i holds the queue head; requests stop while queued+pending would exceed 2.
// Ports: clk_i, rst_i (sync, active-low), stall_i, redirect_i, redirect_pc_i, imem (master),
//        valid_o, instr_o, pc_o, perf_fetch_cnt_o, perf_redir_cnt_o.
// Build option: define FETCH_PERF_EN to instantiate the consume/redirect counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  instr_fetch_unit_if.master imem,
  output logic               valid_o,
  output logic [DATA_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [31:0]        perf_fetch_cnt_o,
  output logic [31:0]        perf_redir_cnt_o
);
  localparam int                        ENT_W      = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0]         INC        = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0]         ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [FETCH_CNT_W-1:0]    DEPTH      = FETCH_CNT_W'(FETCH_Q_DEPTH);
  localparam logic [ENT_W-1:0]          ENT_RST    = {{ADDR_W{1'b0}}, DATA_W'(INSTR_NOP)};

  fetch_state_e           state;
  logic [ADDR_W-1:0]      pc_q;
  logic [ADDR_W-1:0]      tgt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   req_q;
  logic [ADDR_W-1:0]      pc_inc;
  logic [ADDR_W-1:0]      redir_tgt;
  logic                   q_push;
  logic                   q_pop;
  logic                   q_clear;
  logic                   q_full;
  logic                   q_empty;
  logic [FETCH_CNT_W-1:0] q_cnt;
  logic [FETCH_CNT_W-1:0] q_cnt_nxt;
  logic [ENT_W-1:0]       q_head;

  assign pc_inc    = pc_q + INC;
  assign redir_tgt = redirect_pc_i & ALIGN_MASK;

  // Redirect wins: wrong-path data arriving in the redirect cycle is never queued.
  assign q_clear = redirect_i;
  assign q_pop   = valid_o && !stall_i;
  assign q_push  = (state == S_FETCH) && req_q && imem.imem_ready && !redirect_i
                   && (!q_full || q_pop);
  assign q_cnt_nxt = q_clear ? '0
                   : q_cnt + FETCH_CNT_W'(q_push) - FETCH_CNT_W'(q_pop);

  fetch_queue #(
    .W       (ENT_W),
    .RST_DAT (ENT_RST)
  ) u_fetch_queue (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (q_clear),
    .push     (q_push),
    .push_dat ({pc_inc, imem.imem_rdata}),
    .pop      (q_pop),
    .head_dat (q_head),
    .count    (q_cnt),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign valid_o        = !q_empty;
  assign pc_o           = q_head[ENT_W-1:DATA_W];
  assign instr_o        = q_head[DATA_W-1:0];
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // req/addr are registered from next-cycle occupancy, so stall_i only reaches the
  // request through the queue count.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      pc_q   <= RESET_PC;
      tgt_q  <= RESET_PC;
      addr_q <= '0;
      req_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state  <= S_FETCH;
          req_q  <= 1'b1;
          pc_q   <= redirect_i ? redir_tgt : pc_q;
          addr_q <= redirect_i ? redir_tgt : pc_q;
        end
        S_FETCH: begin
          if (redirect_i) begin
            req_q <= 1'b1;
            if (req_q && !imem.imem_ready) begin
              // Request already on the bus must complete at its old address.
              state <= S_DROP;
              tgt_q <= redir_tgt;
            end else begin
              pc_q   <= redir_tgt;
              addr_q <= redir_tgt;
            end
          end else begin
            req_q <= (q_cnt_nxt < DEPTH);
            if (q_push) begin
              pc_q   <= pc_inc;
              addr_q <= pc_inc;
            end
          end
        end
        S_DROP: begin
          req_q <= 1'b1;
          if (imem.imem_ready) begin
            state  <= S_FETCH;
            pc_q   <= redirect_i ? redir_tgt : tgt_q;
            addr_q <= redirect_i ? redir_tgt : tgt_q;
          end else if (redirect_i) begin
            tgt_q <= redir_tgt;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_redir_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_fetch_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (q_pop)      perf_fetch_q <= perf_fetch_q + 32'd1;
      if (redirect_i) perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_redir_cnt_o = perf_redir_q;
`else
  assign perf_fetch_cnt_o = 32'h0;
  assign perf_redir_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus random traffic.
// Latency: n/a.
// Backpressure: random stall_i and imem_ready drive both flow-control paths.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready_r = 1'b1;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] perf_fetch;
  logic [31:0] perf_redir;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch_unit_if imem_if ();

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_if.imem_ready = ready_r;
  assign imem_if.imem_rdata = memf(imem_if.imem_addr);

  instr_fetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem             (imem_if),
    .valid_o          (valid),
    .instr_o          (instr),
    .pc_o             (pc),
    .perf_fetch_cnt_o (perf_fetch),
    .perf_redir_cnt_o (perf_redir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Model view: the delivered stream is the program-order address sequence restarting at
  // each aligned redirect target; at most two instructions are buffered or requested.
  ent_t        mq[$];
  bit          mdl_en = 0;
  bit          run = 0;
  bit          drop = 0;
  logic [31:0] drop_addr = '0;
  logic [31:0] exp_fetch = '0;
  int unsigned n_cons = 0;
  int unsigned n_redir = 0;

  always @(negedge clk) begin : model
    bit          exp_valid;
    bit          exp_req;
    logic [31:0] exp_addr;
    logic [31:0] tgt;
    ent_t        e;
    exp_valid = (mq.size() != 0);
    exp_req   = run && (drop || mq.size() < 2);
    exp_addr  = drop ? drop_addr : exp_fetch;
    if (mdl_en) begin
      chk("valid_o", {31'b0, valid}, {31'b0, exp_valid});
      chk("imem_req", {31'b0, imem_if.imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_if.imem_addr, exp_addr);
      if (exp_valid) begin
        chk("pc_o", pc, mq[0].pc);
        chk("instr_o", instr, mq[0].instr);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch, n_cons);
      chk("perf_redir", perf_redir, n_redir);
`else
      chk("perf_fetch", perf_fetch, 32'h0);
      chk("perf_redir", perf_redir, 32'h0);
`endif
    end
    // advance the model across the coming posedge
    if (!rst) begin
      mq.delete();
      run = 0; drop = 0; exp_fetch = 32'h0; n_cons = 0; n_redir = 0;
      mdl_en = 1;
    end else if (mdl_en) begin
      tgt = {redirect_pc[31:2], 2'b00};
      if (exp_valid && !stall) begin
        n_cons++;
        e = mq.pop_front();
      end
      if (!run) begin
        run = 1;
        if (redirect) begin n_redir++; exp_fetch = tgt; end
      end else if (redirect) begin
        n_redir++;
        mq.delete();
        if (exp_req && !ready_r) begin
          if (!drop) begin drop = 1; drop_addr = exp_addr; end
        end else begin
          drop = 0;
        end
        exp_fetch = tgt;
      end else if (exp_req && ready_r) begin
        if (drop) drop = 0;
        else begin
          mq.push_back('{pc: exp_addr + 32'd4, instr: memf(exp_addr)});
          exp_fetch = exp_addr + 32'd4;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0; stall = 0; redirect = 0; ready_r = 1; redirect_pc = 32'h0;
    repeat (3) step();
    chk("rst valid_o", {31'b0, valid}, 32'h0);
    chk("rst imem_req", {31'b0, imem_if.imem_req}, 32'h0);
    chk("rst imem_addr", imem_if.imem_addr, 32'h0);
    chk("rst instr_o", instr, 32'h0);
    chk("rst pc_o", pc, 32'h0);
    chk("rst perf_fetch", perf_fetch, 32'h0);
    chk("rst perf_redir", perf_redir, 32'h0);
    rst = 1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(imem_if.imem_req && imem_if.imem_addr == a) && n < 50);
    chk("wait_addr", imem_if.imem_addr, a);
  endtask

  initial begin
    // 1: sequential fetch with ready tied high
    do_reset();
    step();
    chk("t1 req0", {31'b0, imem_if.imem_req}, 32'h1);
    chk("t1 addr0", imem_if.imem_addr, 32'h0);
    chk("t1 valid0", {31'b0, valid}, 32'h0);
    step();
    chk("t1 addr1", imem_if.imem_addr, 32'h4);
    chk("t1 valid1", {31'b0, valid}, 32'h1);
    chk("t1 pc1", pc, 32'h4);
    chk("t1 instr1", instr, memf(32'h0));
    step();
    chk("t1 addr2", imem_if.imem_addr, 32'h8);
    chk("t1 pc2", pc, 32'h8);
    step();
    chk("t1 pc3", pc, 32'hC);

    // 2: memory wait states on addr 8
    do_reset();
    wait_addr(32'h8);
    ready_r = 0;
    repeat (3) step();
    chk("t2 valid drained", {31'b0, valid}, 32'h0);
    chk("t2 addr held", imem_if.imem_addr, 32'h8);
    chk("t2 req held", {31'b0, imem_if.imem_req}, 32'h1);
    ready_r = 1;
    step();
    chk("t2 valid back", {31'b0, valid}, 32'h1);
    chk("t2 pc", pc, 32'hC);
    chk("t2 instr", instr, memf(32'h8));

    // 3: downstream stall fills the queue
    stall = 1;
    repeat (5) step();
    chk("t3 req off", {31'b0, imem_if.imem_req}, 32'h0);
    chk("t3 valid", {31'b0, valid}, 32'h1);
    chk("t3 pc frozen", pc, 32'hC);
    stall = 0;
    step();
    chk("t3 pc next", pc, 32'h10);
    chk("t3 req back", {31'b0, imem_if.imem_req}, 32'h1);
    chk("t3 addr", imem_if.imem_addr, 32'h10);
    repeat (3) step();

    // 4: redirect while a request is stuck on the bus
    do_reset();
    wait_addr(32'h10);
    ready_r = 0; redirect = 1; redirect_pc = 32'h100;
    step();
    redirect = 0;
    chk("t4 valid cleared", {31'b0, valid}, 32'h0);
    chk("t4 addr held", imem_if.imem_addr, 32'h10);
    step();
    ready_r = 1;
    step();
    chk("t4 new addr", imem_if.imem_addr, 32'h100);
    chk("t4 valid off", {31'b0, valid}, 32'h0);
    step();
    chk("t4 pc", pc, 32'h104);
    chk("t4 instr", instr, memf(32'h100));

    // 5: redirect with full queue under stall, unaligned target
    stall = 1;
    repeat (3) step();
    chk("t5 full req off", {31'b0, imem_if.imem_req}, 32'h0);
    redirect = 1; redirect_pc = 32'h203;
    step();
    redirect = 0; stall = 0;
    chk("t5 cleared", {31'b0, valid}, 32'h0);
    chk("t5 addr", imem_if.imem_addr, 32'h200);
    step();
    chk("t5 pc", pc, 32'h204);

    // 6: performance counters (10 consumes, 2 redirects)
    do_reset();
    repeat (12) step();
    stall = 1; redirect = 1; redirect_pc = 32'h40;
    step();
    step();
    redirect = 0;
`ifdef FETCH_PERF_EN
    chk("t6 perf_fetch", perf_fetch, 32'd10);
    chk("t6 perf_redir", perf_redir, 32'd2);
`else
    chk("t6 perf_fetch", perf_fetch, 32'd0);
    chk("t6 perf_redir", perf_redir, 32'd0);
`endif
    stall = 0;
    step();

    // PC wrap at the top of the address space
    redirect = 1; redirect_pc = 32'hFFFF_FFFA;
    step();
    redirect = 0;
    chk("wrap addr0", imem_if.imem_addr, 32'hFFFF_FFF8);
    step();
    step();
    chk("wrap addr2", imem_if.imem_addr, 32'h0);
    chk("wrap pc", pc, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 599) != 0);
      stall       = ($urandom_range(0, 2) == 0);
      ready_r     = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      step();
    end
    rst = 1; redirect = 0; stall = 0; ready_r = 1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
